// File: rtl/div_32_seq_pkg.sv
// Shared ALU definitions: function-select codes for the multiply/divide
// unit, default operand width and the divider state encoding.
package div_32_seq_pkg;

   localparam int         DIV_WIDTH = 32;
   localparam logic [4:0] FS_MUL    = 5'h1E;
   localparam logic [4:0] FS_DIV    = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage : div_32_seq_pkg

// File: rtl/div_32_seq_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes.
// {R,Q} shifts left by one; if the shifted remainder is at least the
// divisor magnitude, the divisor is subtracted and a 1 enters Q[0].
module div_step
   import div_32_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] r_sh_d;
   logic           fits_d;

   // Shift-and-trial: the shifted remainder needs one extra bit because
   // the divisor magnitude can be 2^(WIDTH-1). The compare is the sign
   // test of the trial subtraction; when it fits, the difference is
   // below the divisor, so the low WIDTH bits hold it exactly.
   always_comb begin
      r_sh_d = {r_i, q_i[WIDTH-1]};
      fits_d = (r_sh_d >= {1'b0, d_i});
      if (fits_d) begin
         r_o = r_sh_d[WIDTH-1:0] - d_i;
         q_o = {q_i[WIDTH-2:0], 1'b1};
      end else begin
         r_o = r_sh_d[WIDTH-1:0];
         q_o = {q_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule : div_step

// File: rtl/div_32_seq.sv
// div_32_seq: iterative signed divider for the MIPS ALU. Quotient goes to
// Y_lo, remainder to Y_hi (HI/LO convention). Remainder takes the sign of
// the dividend. A zero divisor completes in one clock with Y_lo all ones
// and Y_hi equal to the dividend.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the DZ divide-by-zero flag.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start with FS==FS_DIV; operands sampled here
//   RUN     | one restoring step per clock, 32 steps (down-counter)
//   FIX     | apply quotient/remainder signs, update N and Z
//   DONE    | done pulse for one cycle, then back to IDLE
module div_32_seq
   import div_32_seq_pkg::*;
#(
   parameter int         WIDTH  = DIV_WIDTH,
   parameter logic [4:0] FS_DIV = div_32_seq_pkg::FS_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       FS,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] T,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y_hi,
   output logic [WIDTH-1:0] Y_lo,
   output logic             N,
   output logic             Z
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic             DZ
`endif
);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] dmag_q;
   logic             sign_quo_q;
   logic             sign_rem_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] y_hi_q;
   logic [WIDTH-1:0] y_lo_q;
   logic             n_q;
   logic             z_q;
`ifdef DIV_ZERO_FLAG_EN
   logic             dz_q;
`endif

   logic [WIDTH-1:0] s_mag_d;
   logic [WIDTH-1:0] t_mag_d;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] y_lo_fix_d;
   logic [WIDTH-1:0] y_hi_fix_d;
   logic             launch_d;

   // Operand magnitudes (the most negative value maps to unsigned 2^31)
   // and the signed fix-up of the finished quotient and remainder.
   always_comb begin
      s_mag_d    = S[WIDTH-1] ? -S : S;
      t_mag_d    = T[WIDTH-1] ? -T : T;
      y_lo_fix_d = sign_quo_q ? -q_q : q_q;
      y_hi_fix_d = sign_rem_q ? -r_q : r_q;
      launch_d   = start && (FS == FS_DIV);
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (dmag_q),
      .r_o (r_d),
      .q_o (q_d)
   );

   // Sequencer, iteration datapath and registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         r_q        <= '0;
         q_q        <= '0;
         dmag_q     <= '0;
         sign_quo_q <= 1'b0;
         sign_rem_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         y_hi_q     <= '0;
         y_lo_q     <= '0;
         n_q        <= 1'b0;
         z_q        <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         dz_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (launch_d) begin
                  sign_quo_q <= S[WIDTH-1] ^ T[WIDTH-1];
                  sign_rem_q <= S[WIDTH-1];
                  dmag_q     <= t_mag_d;
`ifdef DIV_ZERO_FLAG_EN
                  dz_q       <= (T == '0);
`endif
                  if (T != '0) begin
                     r_q     <= '0;
                     q_q     <= s_mag_d;
                     cnt_q   <= CNT_LAST;
                     busy_q  <= 1'b1;
                     state_q <= ST_RUN;
                  end else begin
                     y_lo_q  <= '1;
                     y_hi_q  <= S;
                     n_q     <= 1'b1;
                     z_q     <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               r_q <= r_d;
               q_q <= q_d;
               if (cnt_q == '0) begin
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_FIX: begin
               y_lo_q  <= y_lo_fix_d;
               y_hi_q  <= y_hi_fix_d;
               n_q     <= y_lo_fix_d[WIDTH-1];
               z_q     <= (y_lo_fix_d == '0);
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Y_hi = y_hi_q;
   assign Y_lo = y_lo_q;
   assign N    = n_q;
   assign Z    = z_q;
`ifdef DIV_ZERO_FLAG_EN
   assign DZ   = dz_q;
`endif

endmodule : div_32_seq

// File: tb/tb_div_32_seq.sv
// Directed bench for div_32_seq: hand-computed quotient/remainder vectors,
// latency, ignored starts, reset abort and the divide-by-zero path.
module tb_div_32_seq;

   localparam logic [4:0] FS_DIV_C = 5'h1F;
   localparam logic [4:0] FS_MUL_C = 5'h1E;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  FS;
   logic [31:0] S;
   logic [31:0] T;
   logic        busy;
   logic        done;
   logic [31:0] Y_hi;
   logic [31:0] Y_lo;
   logic        N;
   logic        Z;
`ifdef DIV_ZERO_FLAG_EN
   logic        DZ;
`endif

   int vecs = 0;
   int miscompares = 0;
   int lat;
   int ndone;

   always #5 clk = ~clk;

   div_32_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .FS    (FS),
      .S     (S),
      .T     (T),
      .busy  (busy),
      .done  (done),
      .Y_hi  (Y_hi),
      .Y_lo  (Y_lo),
      .N     (N),
      .Z     (Z)
`ifdef DIV_ZERO_FLAG_EN
      ,
      .DZ    (DZ)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] t, input logic [4:0] fs);
      start = 1'b1;
      FS    = fs;
      S     = s;
      T     = t;
      @(posedge clk);
      #1;
      start = 1'b0;
      FS    = 5'h00;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) n++;
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      FS    = 5'h00;
      S     = '0;
      T     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_y_hi", Y_hi, 32'd0);
      chk("rst_y_lo", Y_lo, 32'd0);
      chk("rst_n",    {31'b0, N}, 32'd0);
      chk("rst_z",    {31'b0, Z}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
      chk("rst_dz",   {31'b0, DZ}, 32'd0);
`endif
      reset = 1'b0;

      // 7 / 2
      launch(32'd7, 32'd2, FS_DIV_C);
      chk("p7_busy_run", {31'b0, busy}, 32'd1);
      chk("p7_hold_run", Y_lo, 32'd0);
      wait_done(lat);
      chk("p7_latency", lat, 32'd33);
      chk("p7_y_lo", Y_lo, 32'd3);
      chk("p7_y_hi", Y_hi, 32'd1);
      chk("p7_n", {31'b0, N}, 32'd0);
      chk("p7_z", {31'b0, Z}, 32'd0);
      chk("p7_busy_done", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("p7_done_pulse", {31'b0, done}, 32'd0);

      // -7 / 2
      launch(32'hFFFF_FFF9, 32'd2, FS_DIV_C);
      wait_done(lat);
      chk("m7_latency", lat, 32'd33);
      chk("m7_y_lo", Y_lo, 32'hFFFF_FFFD);
      chk("m7_y_hi", Y_hi, 32'hFFFF_FFFF);
      chk("m7_n", {31'b0, N}, 32'd1);
      @(posedge clk);
      #1;

      // 100 / 0
      launch(32'd100, 32'd0, FS_DIV_C);
      wait_done(lat);
      chk("dz_latency", lat, 32'd0);
      chk("dz_y_lo", Y_lo, 32'hFFFF_FFFF);
      chk("dz_y_hi", Y_hi, 32'd100);
`ifdef DIV_ZERO_FLAG_EN
      chk("dz_flag", {31'b0, DZ}, 32'd1);
`endif
      @(posedge clk);
      #1;
      chk("dz_done_pulse", {31'b0, done}, 32'd0);

      // most negative / -1
      launch(32'h8000_0000, 32'hFFFF_FFFF, FS_DIV_C);
`ifdef DIV_ZERO_FLAG_EN
      chk("ov_dz_clear", {31'b0, DZ}, 32'd0);
`endif
      wait_done(lat);
      chk("ov_latency", lat, 32'd33);
      chk("ov_y_lo", Y_lo, 32'h8000_0000);
      chk("ov_y_hi", Y_hi, 32'd0);
      chk("ov_n", {31'b0, N}, 32'd1);
      @(posedge clk);
      #1;

      // 3 / 5
      launch(32'd3, 32'd5, FS_DIV_C);
      wait_done(lat);
      chk("p3_y_lo", Y_lo, 32'd0);
      chk("p3_y_hi", Y_hi, 32'd3);
      chk("p3_z", {31'b0, Z}, 32'd1);
      @(posedge clk);
      #1;

      // start with the multiply code must not launch a divide
      launch(32'd5, 32'd1, FS_MUL_C);
      chk("fs_busy", {31'b0, busy}, 32'd0);
      count_done(40, ndone);
      chk("fs_no_done", ndone, 32'd0);
      chk("fs_hold_y_hi", Y_hi, 32'd3);

      // second start mid-divide with new operands is ignored
      launch(32'd7, 32'd2, FS_DIV_C);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      FS    = FS_DIV_C;
      S     = 32'd99;
      T     = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      FS    = 5'h00;
      S     = 32'd0;
      T     = 32'd0;
      count_done(40, ndone);
      chk("ign_done_count", ndone, 32'd1);
      chk("ign_y_lo", Y_lo, 32'd3);
      chk("ign_y_hi", Y_hi, 32'd1);

      // reset part-way through a divide
      launch(32'hFFFF_FFF9, 32'd2, FS_DIV_C);
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("ab_busy", {31'b0, busy}, 32'd0);
      chk("ab_done", {31'b0, done}, 32'd0);
      chk("ab_y_lo", Y_lo, 32'd0);
      chk("ab_y_hi", Y_hi, 32'd0);
      chk("ab_n", {31'b0, N}, 32'd0);
      count_done(40, ndone);
      chk("ab_no_done", ndone, 32'd0);

      // 9 / 3 after the abort
      launch(32'd9, 32'd3, FS_DIV_C);
      wait_done(lat);
      chk("p9_latency", lat, 32'd33);
      chk("p9_y_lo", Y_lo, 32'd3);
      chk("p9_y_hi", Y_hi, 32'd0);
      chk("p9_z", {31'b0, Z}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule : tb_div_32_seq
